// File: rtl/bitty_fetch_seq.sv
// bitty_fetch_seq: instruction fetch sequencer for the BittyPro core.
// Owns the program counter. For each instruction it issues a one-cycle read
// to instruction memory, waits for the response, presents the instruction
// to the core with a one-cycle inst_valid pulse, then waits for done. The
// next pc is either pc+1 (wrapping) or the branch target.
// Fetching HALT_INST parks the sequencer in HALT without issuing that word.
//
// Optional feature macro: BITTY_FETCH_WATCHDOG_EN
//   When defined, an EXEC watchdog raises fault and enters HALT after TIMEOUT
//   EXEC cycles without done.
//   When undefined, fault is tied low and EXEC waits indefinitely.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | after reset; waiting for start
// S_FETCH  | mem_rd high for this single cycle, mem_addr = pc
// S_WAIT   | waiting for mem_valid; responses arriving in other states are dropped
// S_ISSUE  | inst_valid high for this single cycle
// S_EXEC   | waiting for the core's done; branch_en/branch_addr pick the next pc
// S_HALT   | halt word fetched (or watchdog fault); start restarts at pc 0
module bitty_fetch_seq #(
    parameter int                ADDR_W    = 8,
    parameter int                INST_W    = 16,
    parameter logic [INST_W-1:0] HALT_INST = 16'hFFFF,
    parameter int                TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [INST_W-1:0] instruction,
    output logic              inst_valid,
    input  logic              done,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_EXEC  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t state;

`ifdef BITTY_FETCH_WATCHDOG_EN
    // Down-counter loaded on EXEC entry; terminal count 0 marks the
    // TIMEOUT-th EXEC cycle without done.
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;
`else
    // Without the watchdog TIMEOUT has no effect.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign fault          = 1'b0;
`endif

    // The read address is simply the program counter.
    assign mem_addr = pc;

    // Sequencer FSM; all outputs except mem_addr are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            instruction <= '0;
            mem_rd      <= 1'b0;
            inst_valid  <= 1'b0;
            halted      <= 1'b0;
`ifdef BITTY_FETCH_WATCHDOG_EN
            fault       <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            mem_rd     <= 1'b0;
            inst_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_FETCH;
                        mem_rd <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        if (mem_rdata == HALT_INST) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            instruction <= mem_rdata;
                            inst_valid  <= 1'b1;
                            state       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_EXEC;
`ifdef BITTY_FETCH_WATCHDOG_EN
                    wd_cnt <= WD_LOAD;
`endif
                end
                S_EXEC: begin
                    // done on the terminal-count cycle still completes normally
                    if (done) begin
                        pc     <= branch_en ? branch_addr : pc + ADDR_W'(1);
                        state  <= S_FETCH;
                        mem_rd <= 1'b1;
                    end
`ifdef BITTY_FETCH_WATCHDOG_EN
                    else if (wd_cnt == '0) begin
                        fault  <= 1'b1;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        wd_cnt <= wd_cnt - WD_W'(1);
                    end
`endif
                end
                S_HALT: begin
                    if (start) begin
                        pc     <= '0;
                        halted <= 1'b0;
`ifdef BITTY_FETCH_WATCHDOG_EN
                        fault  <= 1'b0;
`endif
                        state  <= S_FETCH;
                        mem_rd <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitty_fetch_seq.sv
// Testbench for bitty_fetch_seq: a cycle table, hand-written corner
// sequences, and random programs checked against a program-walk model.
module tb_bitty_fetch_seq;

    localparam logic [15:0] HALT = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset, start, mem_valid, done, branch_en;
    logic [15:0] mem_rdata;
    logic [7:0]  branch_addr;
    logic        mem_rd, inst_valid, halted, fault;
    logic [7:0]  mem_addr, pc;
    logic [15:0] instruction;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] prog [256];
    bit          br_en_q [$];
    logic [7:0]  br_to_q [$];

    bitty_fetch_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .done        (done),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .pc          (pc),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, st, mv;
        logic [15:0] rdata;
        logic        dn, be;
        logic [7:0]  ba;
        logic        e_rd, e_iv, e_h;
        logic [7:0]  e_pc;
        logic [15:0] e_inst;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(logic rst, logic st, logic mv, logic [15:0] rdata,
                                logic dn, logic be, logic [7:0] ba,
                                logic e_rd, logic e_iv, logic e_h,
                                logic [7:0] e_pc, logic [15:0] e_inst);
        vec_t v;
        v.rst = rst; v.st = st; v.mv = mv; v.rdata = rdata;
        v.dn = dn; v.be = be; v.ba = ba;
        v.e_rd = e_rd; v.e_iv = e_iv; v.e_h = e_h; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compares {mem_rd, inst_valid, halted, fault, mem_addr, pc, instruction}.
    task automatic chk_state(input string name, input logic e_rd, input logic e_iv,
                             input logic e_h, input logic e_f, input logic [7:0] e_pc,
                             input logic [15:0] e_inst);
        check(name,
              {28'd0, mem_rd, inst_valid, halted, fault, mem_addr, pc, instruction},
              {28'd0, e_rd, e_iv, e_h, e_f, e_pc, e_pc, e_inst});
    endtask

    task automatic idle_inputs();
        reset = 1'b0; start = 1'b0; mem_valid = 1'b0; mem_rdata = 16'h0;
        done = 1'b0; branch_en = 1'b0; branch_addr = 8'h0;
    endtask

    // Random program whose walk under the chosen branch decisions ends on a
    // HALT word at an address not visited before.
    task automatic gen_prog();
        bit          seen [256];
        logic [7:0]  p, t;
        logic [15:0] v;
        bit          b;
        int          k;
        for (int i = 0; i < 256; i++) begin
            seen[i] = 1'b0;
            v = 16'($urandom);
            while (v == HALT) v = 16'($urandom);
            prog[i] = v;
        end
        br_en_q.delete();
        br_to_q.delete();
        k = $urandom_range(2, 12);
        p = 8'h0;
        seen[0] = 1'b1;
        for (int s = 0; s < k; s++) begin
            b = ($urandom_range(0, 2) == 0);
            t = 8'($urandom);
            if (s == k - 1) begin
                b = 1'b1;
                while (seen[t]) t = 8'($urandom);
            end
            br_en_q.push_back(b);
            br_to_q.push_back(t);
            p = b ? t : p + 8'd1;
            seen[p] = 1'b1;
        end
        prog[p] = HALT;
    endtask

    // Starts the DUT (from IDLE or HALT), serves memory with random latency,
    // acknowledges each instruction after a random delay using the queued
    // branch decisions, and compares the fetch/issue trace with the model.
    task automatic run_prog(input int max_cyc);
        logic [7:0]  mpc, last_a;
        logic [15:0] exp_i [$];
        logic [7:0]  exp_a [$];
        logic [15:0] got_i [$];
        logic [7:0]  got_a [$];
        logic [1:0]  exp_hv;
        int          k, resp_cnt, done_cnt, cyc;
        bit          exp_rd, exp_iv, fin;

        // Model: walk the program, one entry per executed instruction.
        mpc = 8'h0;
        k = 0;
        for (int s = 0; s < 300; s++) begin
            exp_a.push_back(mpc);
            if (prog[mpc] == HALT) break;
            exp_i.push_back(prog[mpc]);
            if (k < br_en_q.size() && br_en_q[k]) mpc = br_to_q[k];
            else mpc = mpc + 8'd1;
            k++;
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        exp_rd = 1'b1; exp_iv = 1'b0; exp_hv = 2'b00;
        resp_cnt = 0; done_cnt = 0; k = 0; cyc = 0; fin = 1'b0; last_a = 8'h0;
        while (!fin) begin
            if (exp_rd) begin
                check("fetch_latency", 64'(mem_rd), 64'(1));
                exp_rd = 1'b0;
            end
            if (exp_iv) begin
                check("issue_latency", 64'({inst_valid, halted}), 64'(exp_hv));
                exp_iv = 1'b0;
            end
            if (mem_rd || inst_valid) check("rd_iv_exclusive", 64'(mem_rd & inst_valid), 64'(0));
            if (mem_rd) begin
                got_a.push_back(mem_addr);
                last_a = mem_addr;
            end
            if (inst_valid) got_i.push_back(instruction);

            if (halted) begin
                fin = 1'b1;
            end else if (cyc >= max_cyc) begin
                check("run_cycle_budget", 64'(cyc), 64'(0));
                fin = 1'b1;
            end else begin
                mem_valid   = 1'b0;
                mem_rdata   = 16'($urandom);
                done        = 1'b0;
                branch_en   = 1'($urandom);
                branch_addr = 8'($urandom);
                if (mem_rd) begin
                    resp_cnt = $urandom_range(1, 4);
                    if ($urandom_range(0, 3) == 0) begin
                        mem_valid = 1'b1;
                        mem_rdata = HALT;
                    end
                end else if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        mem_valid = 1'b1;
                        mem_rdata = prog[last_a];
                        exp_iv    = 1'b1;
                        exp_hv    = (prog[last_a] == HALT) ? 2'b01 : 2'b10;
                    end
                end else if (done_cnt > 0 && $urandom_range(0, 2) == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = HALT;
                end
                if (inst_valid) begin
                    done_cnt = $urandom_range(1, 5);
                    done     = 1'($urandom);
                end else if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        done        = 1'b1;
                        branch_en   = (k < br_en_q.size()) ? br_en_q[k] : 1'b0;
                        branch_addr = (k < br_to_q.size()) ? br_to_q[k] : 8'h0;
                        k++;
                        exp_rd = 1'b1;
                    end
                end else begin
                    done = 1'($urandom);
                end
                tick();
                cyc++;
            end
        end
        idle_inputs();

        check("fetch_count", 64'(got_a.size()), 64'(exp_a.size()));
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
            check($sformatf("fetch_addr[%0d]", i), 64'(got_a[i]), 64'(exp_a[i]));
        check("issue_count", 64'(got_i.size()), 64'(exp_i.size()));
        for (int i = 0; i < got_i.size() && i < exp_i.size(); i++)
            check($sformatf("issue_inst[%0d]", i), 64'(got_i[i]), 64'(exp_i[i]));
        check("halt_flag", 64'(halted), 64'(1));
        check("halt_pc", 64'(pc), 64'(mpc));
        if (exp_i.size() > 0)
            check("halt_inst_held", 64'(instruction), 64'(exp_i[exp_i.size()-1]));
        if (!halted) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        //            rst st mv rdata     dn be ba     | rd iv h  pc     inst
        tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 8'h00,   0, 0, 0, 8'h00, 16'h0000);
        tbl[1]  = mk(0, 1, 0, 16'h0000, 0, 0, 8'h00,   1, 0, 0, 8'h00, 16'h0000);
        tbl[2]  = mk(0, 0, 0, 16'h0000, 1, 0, 8'h00,   0, 0, 0, 8'h00, 16'h0000);
        tbl[3]  = mk(0, 0, 0, 16'h0000, 1, 1, 8'h77,   0, 0, 0, 8'h00, 16'h0000);
        tbl[4]  = mk(0, 0, 1, 16'h1234, 0, 0, 8'h00,   0, 1, 0, 8'h00, 16'h1234);
        tbl[5]  = mk(0, 1, 0, 16'h0000, 1, 1, 8'h99,   0, 0, 0, 8'h00, 16'h1234);
        tbl[6]  = mk(0, 0, 1, 16'hFFFF, 0, 0, 8'h00,   0, 0, 0, 8'h00, 16'h1234);
        tbl[7]  = mk(0, 0, 0, 16'h0000, 1, 1, 8'h40,   1, 0, 0, 8'h40, 16'h1234);
        tbl[8]  = mk(0, 0, 1, 16'hFFFF, 0, 0, 8'h00,   0, 0, 0, 8'h40, 16'h1234);
        tbl[9]  = mk(0, 0, 1, 16'h0001, 0, 0, 8'h00,   0, 1, 0, 8'h40, 16'h0001);
        tbl[10] = mk(0, 0, 0, 16'h0000, 0, 0, 8'h00,   0, 0, 0, 8'h40, 16'h0001);
        tbl[11] = mk(0, 0, 0, 16'h0000, 1, 1, 8'hFF,   1, 0, 0, 8'hFF, 16'h0001);
        tbl[12] = mk(0, 0, 0, 16'h0000, 0, 0, 8'h00,   0, 0, 0, 8'hFF, 16'h0001);
        tbl[13] = mk(0, 0, 0, 16'h0000, 0, 0, 8'h00,   0, 0, 0, 8'hFF, 16'h0001);
        tbl[14] = mk(0, 0, 1, 16'h0002, 0, 0, 8'h00,   0, 1, 0, 8'hFF, 16'h0002);
        tbl[15] = mk(0, 0, 0, 16'h0000, 0, 0, 8'h00,   0, 0, 0, 8'hFF, 16'h0002);
        tbl[16] = mk(0, 0, 0, 16'h0000, 1, 0, 8'h12,   1, 0, 0, 8'h00, 16'h0002);
        tbl[17] = mk(0, 0, 0, 16'h0000, 0, 0, 8'h00,   0, 0, 0, 8'h00, 16'h0002);

        for (int i = 0; i < 18; i++) begin
            reset = tbl[i].rst; start = tbl[i].st; mem_valid = tbl[i].mv;
            mem_rdata = tbl[i].rdata; done = tbl[i].dn; branch_en = tbl[i].be;
            branch_addr = tbl[i].ba;
            tick();
            chk_state($sformatf("table_row%0d", i), tbl[i].e_rd, tbl[i].e_iv, tbl[i].e_h,
                      1'b0, tbl[i].e_pc, tbl[i].e_inst);
        end
        idle_inputs();

        // Reset while waiting for memory; the late response must be dropped.
        reset = 1'b1;
        tick();
        chk_state("reset_in_wait", 0, 0, 0, 0, 8'h00, 16'h0000);
        reset = 1'b0; mem_valid = 1'b1; mem_rdata = 16'h5555;
        tick();
        chk_state("late_resp_after_reset", 0, 0, 0, 0, 8'h00, 16'h0000);
        mem_valid = 1'b0;
        repeat (3) tick();
        chk_state("idle_holds", 0, 0, 0, 0, 8'h00, 16'h0000);

        // Sequential program of three instructions ending in HALT at address 3.
        for (int i = 0; i < 256; i++) prog[i] = 16'h0100 + 16'(i);
        prog[0] = 16'h00A1; prog[1] = 16'h00B2; prog[2] = 16'h00C3; prog[3] = HALT;
        br_en_q.delete(); br_to_q.delete();
        for (int i = 0; i < 3; i++) begin
            br_en_q.push_back(1'b0);
            br_to_q.push_back(8'h00);
        end
        run_prog(200);
        chk_state("seq_halt", 0, 0, 1, 0, 8'h03, 16'h00C3);
        repeat (2) tick();
        chk_state("halt_holds", 0, 0, 1, 0, 8'h03, 16'h00C3);

        // Random programs, each restarted from HALT.
        for (int r = 0; r < 25; r++) begin
            gen_prog();
            run_prog(2000);
        end

`ifdef BITTY_FETCH_WATCHDOG_EN
        prog[0] = 16'h0A0A;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mem_valid = 1'b1; mem_rdata = 16'h0A0A;
        tick();
        mem_valid = 1'b0;
        chk_state("wd_issue", 0, 1, 0, 0, 8'h00, 16'h0A0A);
        repeat (64) tick();
        chk_state("wd_last_exec_cycle", 0, 0, 0, 0, 8'h00, 16'h0A0A);
        tick();
        chk_state("wd_fault", 0, 0, 1, 1, 8'h00, 16'h0A0A);
        repeat (3) tick();
        chk_state("wd_fault_sticky", 0, 0, 1, 1, 8'h00, 16'h0A0A);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_state("wd_restart", 1, 0, 0, 0, 8'h00, 16'h0A0A);
        tick();
        mem_valid = 1'b1; mem_rdata = 16'h0B0B;
        tick();
        mem_valid = 1'b0;
        repeat (64) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_state("wd_done_on_limit", 1, 0, 0, 0, 8'h01, 16'h0B0B);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
